// File: rtl/xillybus_wr128_ap_fifo_bridge.sv
// Bridges one Xillybus 128-bit host-to-FPGA write channel into an HLS
// ap_fifo read port through a first-word-fall-through FIFO, with sticky
// error flags and an accepted-word counter for debug.
module xillybus_wr128_ap_fifo_bridge #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  input  logic              user_w_open,
  input  logic              user_w_wren,
  input  logic [DATA_W-1:0] user_w_data,
  output logic              user_w_full,
  output logic [DATA_W-1:0] ap_dout,
  output logic              ap_empty_n,
  input  logic              ap_read,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  output logic [31:0]       words_in
);

  localparam int unsigned     DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              open_q;

  logic              flush;
  logic              wr_ok;
  logic              rd_ok;
  logic              wr_drop;
  logic              rd_drop;
  logic [ADDR_W:0]   level_next;

  // Acceptance decisions and next occupancy, all from pre-edge level.
  always_comb begin
    flush      = user_w_open & ~open_q;
    wr_ok      = user_w_wren && (level != FULL_LVL) && !flush;
    rd_ok      = ap_read && (level != '0) && !flush;
    wr_drop    = user_w_wren && (level == FULL_LVL) && !flush;
    rd_drop    = ap_read && (level == '0) && !flush;
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   level_next = level + 1'b1;
        2'b01:   level_next = level - 1'b1;
        default: level_next = level;
      endcase
    end
  end

  // Control state: pointers, occupancy, registered flags, debug counters.
  always_ff @(posedge bus_clk) begin
    // open_q tracks the input even in reset so that a channel already open
    // when reset is released is not mistaken for a fresh open (which would
    // discard the first write).
    open_q <= user_w_open;
    if (bus_rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      user_w_full <= 1'b0;
      ap_empty_n  <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      words_in    <= '0;
    end else if (flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      user_w_full <= 1'b0;
      ap_empty_n  <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      words_in    <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr   <= wr_ptr + 1'b1;
        words_in <= words_in + 32'd1;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_drop) begin
        overflow <= 1'b1;
      end
      if (rd_drop) begin
        underflow <= 1'b1;
      end
      level       <= level_next;
      user_w_full <= (level_next == FULL_LVL);
      ap_empty_n  <= (level_next != '0);
    end
  end

  // Storage array; contents need no reset since ap_empty_n qualifies them.
  always_ff @(posedge bus_clk) begin
    if (!bus_rst && wr_ok) begin
      mem[wr_ptr] <= user_w_data;
    end
  end

  assign ap_dout = mem[rd_ptr];

endmodule

// File: tb/tb_xillybus_wr128_ap_fifo_bridge.sv
// Directed bench for xillybus_wr128_ap_fifo_bridge.
module tb_xillybus_wr128_ap_fifo_bridge;

  logic         bus_clk = 1'b0;
  logic         bus_rst;
  logic         user_w_open;
  logic         user_w_wren;
  logic [127:0] user_w_data;
  logic         user_w_full;
  logic [127:0] ap_dout;
  logic         ap_empty_n;
  logic         ap_read;
  logic [4:0]   level;
  logic         overflow;
  logic         underflow;
  logic [31:0]  words_in;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  xillybus_wr128_ap_fifo_bridge #(.DATA_W(128), .ADDR_W(4)) dut (
    .bus_clk     (bus_clk),
    .bus_rst     (bus_rst),
    .user_w_open (user_w_open),
    .user_w_wren (user_w_wren),
    .user_w_data (user_w_data),
    .user_w_full (user_w_full),
    .ap_dout     (ap_dout),
    .ap_empty_n  (ap_empty_n),
    .ap_read     (ap_read),
    .level       (level),
    .overflow    (overflow),
    .underflow   (underflow),
    .words_in    (words_in)
  );

  always #5 bus_clk = ~bus_clk;

  // Advance one clock; outputs are sampled 1 ns after the rising edge.
  task automatic step();
    @(posedge bus_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int bad_data;
    int bad_level;

    bus_rst     = 1'b1;
    user_w_open = 1'b1;
    user_w_wren = 1'b0;
    user_w_data = '0;
    ap_read     = 1'b0;
    step();
    step();
    bus_rst = 1'b0;

    chk("rst_level", 128'(level), 128'd0);
    chk("rst_full", 128'(user_w_full), 128'd0);
    chk("rst_empty_n", 128'(ap_empty_n), 128'd0);
    chk("rst_overflow", 128'(overflow), 128'd0);
    chk("rst_underflow", 128'(underflow), 128'd0);
    chk("rst_words_in", 128'(words_in), 128'd0);

    // Single word in, then out.
    user_w_wren = 1'b1;
    user_w_data = 128'h0123456789ABCDEF0123456789ABCDEF;
    step();
    user_w_wren = 1'b0;
    chk("single_empty_n", 128'(ap_empty_n), 128'd1);
    chk("single_dout", ap_dout, 128'h0123456789ABCDEF0123456789ABCDEF);
    chk("single_level", 128'(level), 128'd1);
    chk("single_words_in", 128'(words_in), 128'd1);
    ap_read = 1'b1;
    step();
    ap_read = 1'b0;
    chk("single_pop_empty_n", 128'(ap_empty_n), 128'd0);
    chk("single_pop_level", 128'(level), 128'd0);

    // Fill to full, overflow attempt, drain in order.
    for (int i = 0; i < 16; i++) begin
      user_w_wren = 1'b1;
      user_w_data = 128'(i);
      step();
      if (i == 14) chk("fill_not_full_at_15", 128'(user_w_full), 128'd0);
    end
    chk("fill_full", 128'(user_w_full), 128'd1);
    chk("fill_level", 128'(level), 128'd16);
    user_w_data = 128'd99;
    step();
    user_w_wren = 1'b0;
    chk("ovf_flag", 128'(overflow), 128'd1);
    chk("ovf_level", 128'(level), 128'd16);
    chk("ovf_words_in", 128'(words_in), 128'd17);
    bad_data = 0;
    for (int i = 0; i < 16; i++) begin
      if (ap_dout !== 128'(i) || ap_empty_n !== 1'b1) bad_data++;
      ap_read = 1'b1;
      step();
    end
    ap_read = 1'b0;
    chk("drain_order_errors", 128'(bad_data), 128'd0);
    chk("drain_level", 128'(level), 128'd0);
    chk("drain_empty_n", 128'(ap_empty_n), 128'd0);
    chk("drain_full", 128'(user_w_full), 128'd0);

    // Fresh reset, then concurrent streaming at level 3.
    bus_rst = 1'b1;
    step();
    bus_rst = 1'b0;
    chk("rst2_overflow", 128'(overflow), 128'd0);
    for (int k = 0; k < 3; k++) begin
      user_w_wren = 1'b1;
      user_w_data = 128'(1000 + k);
      step();
    end
    chk("preload_level", 128'(level), 128'd3);
    bad_data  = 0;
    bad_level = 0;
    for (int i = 0; i < 100; i++) begin
      if (ap_dout !== 128'(1000 + i)) bad_data++;
      user_w_wren = 1'b1;
      user_w_data = 128'(1003 + i);
      ap_read     = 1'b1;
      step();
      if (level !== 5'd3) bad_level++;
    end
    user_w_wren = 1'b0;
    ap_read     = 1'b0;
    chk("stream_order_errors", 128'(bad_data), 128'd0);
    chk("stream_level_errors", 128'(bad_level), 128'd0);
    chk("stream_words_in", 128'(words_in), 128'd103);
    bad_data = 0;
    for (int k = 0; k < 3; k++) begin
      if (ap_dout !== 128'(1100 + k)) bad_data++;
      ap_read = 1'b1;
      step();
    end
    ap_read = 1'b0;
    chk("stream_tail_errors", 128'(bad_data), 128'd0);
    chk("stream_tail_level", 128'(level), 128'd0);

    // Read on empty alongside a write.
    ap_read     = 1'b1;
    user_w_wren = 1'b1;
    user_w_data = 128'd7;
    step();
    ap_read     = 1'b0;
    user_w_wren = 1'b0;
    chk("empty_rd_underflow", 128'(underflow), 128'd1);
    chk("empty_rd_level", 128'(level), 128'd1);
    chk("empty_rd_dout", ap_dout, 128'd7);
    chk("empty_rd_empty_n", 128'(ap_empty_n), 128'd1);

    // Open flush with 5 words buffered.
    for (int k = 0; k < 4; k++) begin
      user_w_wren = 1'b1;
      user_w_data = 128'(20 + k);
      step();
    end
    user_w_wren = 1'b0;
    chk("flush_pre_level", 128'(level), 128'd5);
    user_w_open = 1'b0;
    step();
    step();
    step();
    chk("open_low_level", 128'(level), 128'd5);
    chk("open_low_dout", ap_dout, 128'd7);
    user_w_open = 1'b1;
    user_w_wren = 1'b1;
    user_w_data = 128'd55;
    step();
    user_w_wren = 1'b0;
    chk("flush_level", 128'(level), 128'd0);
    chk("flush_empty_n", 128'(ap_empty_n), 128'd0);
    chk("flush_full", 128'(user_w_full), 128'd0);
    chk("flush_words_in", 128'(words_in), 128'd0);
    chk("flush_overflow", 128'(overflow), 128'd0);
    chk("flush_underflow", 128'(underflow), 128'd0);

    // Reset during a full-rate write burst at level 9.
    for (int k = 0; k < 9; k++) begin
      user_w_wren = 1'b1;
      user_w_data = 128'(300 + k);
      step();
    end
    chk("burst_level", 128'(level), 128'd9);
    user_w_data = 128'd309;
    bus_rst     = 1'b1;
    step();
    bus_rst = 1'b0;
    chk("midrst_level", 128'(level), 128'd0);
    chk("midrst_full", 128'(user_w_full), 128'd0);
    chk("midrst_empty_n", 128'(ap_empty_n), 128'd0);
    chk("midrst_words_in", 128'(words_in), 128'd0);
    chk("midrst_overflow", 128'(overflow), 128'd0);
    user_w_data = 128'hAA;
    step();
    user_w_wren = 1'b0;
    chk("resume_level", 128'(level), 128'd1);
    chk("resume_dout", ap_dout, 128'hAA);
    chk("resume_words_in", 128'(words_in), 128'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
